// File: rtl/crc32_pkg.sv
// Shared CRC-32/IEEE constants and elaboration-time helpers for the crc32_enc slice.
// The parallel CRC is affine in {data, init}, so it is captured as a GF(2) matrix built here.
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY   = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;

  localparam int CRC32_MAX_DATA_W = 1024;
  localparam int CRC32_ROW_W      = CRC32_MAX_DATA_W + 32;

  // Row k selects which of {data[i] at bit 32+i, init[j] at bit j} feed CRC bit k.
  typedef logic [CRC32_ROW_W-1:0] crc32_row_t;
  typedef logic [31:0][CRC32_ROW_W-1:0] crc32_mat_t;

  function automatic logic [31:0] crc32_bitrev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Symbolically clocks the reflected LFSR one data bit at a time (byte 0 LSB first
  // is simply data bit 0 upward), tracking each state bit as a mask over the inputs.
  function automatic crc32_mat_t crc32_build_matrix(input int data_w);
    crc32_mat_t  s;
    crc32_row_t  fb;
    logic [31:0] poly_r;
    poly_r = crc32_bitrev(CRC32_POLY);
    for (int k = 0; k < 32; k++) s[k] = crc32_row_t'(1) << k;
    for (int i = 0; i < data_w; i++) begin
      fb = s[0] ^ (crc32_row_t'(1) << (32 + i));
      for (int k = 0; k < 31; k++) s[k] = s[k+1] ^ (poly_r[k] ? fb : {CRC32_ROW_W{1'b0}});
      s[31] = poly_r[31] ? fb : {CRC32_ROW_W{1'b0}};
    end
    return s;
  endfunction

endpackage

// File: rtl/crc32_xor_tree.sv
// Combinational CRC-32/IEEE of one DATA_WIDTH-bit block: one XOR reduction per output bit.
module crc32_xor_tree
  import crc32_pkg::*;
#(
  parameter int DATA_WIDTH = 512
) (
  input  logic [DATA_WIDTH-1:0] data,
  output logic [31:0]           crc
);

  localparam crc32_mat_t MAT = crc32_build_matrix(DATA_WIDTH);

  logic [DATA_WIDTH+31:0] vec;
  assign vec = {data, CRC32_INIT};

  for (genvar k = 0; k < 32; k++) begin : g_bit
    assign crc[k] = (^(MAT[k][DATA_WIDTH+31:0] & vec)) ^ CRC32_XOROUT[k];
  end

endmodule

// File: rtl/crc32_enc.sv
// Two-stage pipelined CRC-32 encoder: forwards each block together with its
// bit-reversed checksum two cycles after it is accepted.
module crc32_enc
  import crc32_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int CRC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CRC_WIDTH-1:0]  checksum_o
);

  if (CRC_WIDTH != 32) begin : g_bad_crc_w
    $error("crc32_enc: CRC_WIDTH must be 32");
  end
  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH > CRC32_MAX_DATA_W) begin : g_bad_data_w
    $error("crc32_enc: DATA_WIDTH must be a multiple of 8 and at most CRC32_MAX_DATA_W");
  end

  logic                  vld_p0;
  logic [DATA_WIDTH-1:0] data_p0;
  logic [31:0]           crc_p0;

  // Stage 1: capture the block; data only loads on valid so idle X never enters
  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= valid_i;
  end

  always_ff @(posedge clk) begin
    if (valid_i) data_p0 <= data_i;
  end

  crc32_xor_tree #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_xor_tree (
    .data(data_p0),
    .crc (crc_p0)
  );

  // Stage 2: register checksum and data; outputs hold while no block completes
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o    <= 1'b0;
      data_o     <= '0;
      checksum_o <= '0;
    end else begin
      valid_o <= vld_p0;
      if (vld_p0) begin
        data_o     <= data_p0;
        checksum_o <= CRC_WIDTH'(crc32_bitrev(crc_p0));
      end
    end
  end

endmodule

// File: tb/tb_crc32_enc.sv
// Directed and random checks of crc32_enc against a byte-serial zlib-style CRC-32 model.
module tb_crc32_enc;

  localparam int DW = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_i;
  logic [DW-1:0] data_i;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic [31:0]   checksum_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  crc32_enc #(
    .DATA_WIDTH(DW),
    .CRC_WIDTH (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (valid_i),
    .data_i    (data_i),
    .valid_o   (valid_o),
    .data_o    (data_o),
    .checksum_o(checksum_o)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // zlib crc32() over all DW/8 bytes, then bit-reversed to match checksum_o.
  function automatic logic [31:0] ref_crc(input logic [DW-1:0] d);
    logic [31:0] c;
    logic [31:0] r;
    c = 32'hFFFFFFFF;
    for (int b = 0; b < DW / 8; b++) begin
      c = c ^ {24'h0, d[8*b +: 8]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    for (int i = 0; i < 32; i++) r[i] = c[31-i];
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_block();
    logic [DW-1:0] d;
    for (int w = 0; w < DW / 32; w++) d[32*w +: 32] = $urandom();
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [DW-1:0] d);
    check({tag, "_vld"}, DW'(valid_o), DW'(1));
    check({tag, "_data"}, data_o, d);
    check({tag, "_crc"}, DW'(checksum_o), DW'(ref_crc(d)));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_vld"}, DW'(valid_o), DW'(0));
    check({tag, "_data"}, data_o, DW'(0));
    check({tag, "_crc"}, DW'(checksum_o), DW'(0));
  endtask

  task automatic send_one(input string tag, input logic [DW-1:0] d, output logic [31:0] got_crc);
    data_i  = d;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    data_i  = 'x;
    check({tag, "_lat1"}, DW'(valid_o), DW'(0));
    step();
    check_out(tag, d);
    got_crc = checksum_o;
    step();
    check({tag, "_after"}, DW'(valid_o), DW'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] blk [16];
    logic [31:0]   c_a, c_b, c_ab, c_tmp;

    rst     = 1'b1;
    valid_i = 1'b1;
    data_i  = rnd_block();
    step();
    check_zero("rst_edge1");
    data_i = rnd_block();
    step();
    check_zero("rst_edge2");
    rst     = 1'b0;
    valid_i = 1'b0;
    data_i  = 'x;
    step();
    check_zero("rst_release");

    send_one("zeros", '0, c_tmp);
    send_one("ones", '1, c_tmp);
    d = '0;
    d[7:0] = 8'h31;
    send_one("byte0_31", d, c_tmp);
    d = '0;
    for (int k = 0; k < 9; k++) d[8*k +: 8] = 8'h31 + 8'(k);
    send_one("digits", d, c_tmp);

    // Held for two cycles: two identical results, then a two-cycle gap.
    for (int n = 0; n < 10; n++) begin
      d       = rnd_block();
      data_i  = d;
      valid_i = 1'b1;
      step();
      check($sformatf("hold%0d_lat1", n), DW'(valid_o), DW'(0));
      step();
      check_out($sformatf("hold%0d_a", n), d);
      valid_i = 1'b0;
      data_i  = 'x;
      step();
      check_out($sformatf("hold%0d_b", n), d);
      step();
      check($sformatf("hold%0d_gap", n), DW'(valid_o), DW'(0));
    end

    for (int i = 0; i < 16; i++) blk[i] = rnd_block();
    for (int i = 0; i < 18; i++) begin
      if (i < 16) begin
        valid_i = 1'b1;
        data_i  = blk[i];
      end else begin
        valid_i = 1'b0;
        data_i  = 'x;
      end
      step();
      if (i >= 1 && i <= 16) check_out($sformatf("b2b%0d", i - 1), blk[i-1]);
      else                   check($sformatf("b2b_idle%0d", i), DW'(valid_o), DW'(0));
    end

    a = rnd_block();
    b = rnd_block();
    send_one("lin_a", a, c_a);
    send_one("lin_b", b, c_b);
    send_one("lin_ab", a ^ b, c_ab);
    check("linearity", DW'(c_a ^ c_b ^ c_ab), DW'(ref_crc('0)));

    for (int i = 0; i < 3; i++) blk[i] = rnd_block();
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1;
      data_i  = blk[i];
      step();
      if (i == 0) check("mid_lat1", DW'(valid_o), DW'(0));
      else        check_out($sformatf("mid%0d", i - 1), blk[i-1]);
    end
    rst    = 1'b1;
    data_i = rnd_block();
    step();
    check_zero("mid_rst1");
    data_i = rnd_block();
    step();
    check_zero("mid_rst2");
    rst     = 1'b0;
    valid_i = 1'b0;
    data_i  = 'x;
    step();
    check_zero("mid_release");
    send_one("post_rst", rnd_block(), c_tmp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
